// File: rtl/mem_fill_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_fill_arbiter
//
// Shares the single memory4c main-memory port between I-cache block fills,
// D-cache block fills and D-cache write-throughs. A granted miss issues the
// WORDS word addresses of its block, one per cycle. Each returning word is
// steered to the owning cache with a write strobe and word index. The
// owning cache then gets a one-cycle done pulse so it can update
// tag/valid/LRU.
//
// Optional build macro:
//   MEM_ARB_FAIR_EN - when both misses are pending, alternate between the
//                     I- and D-side instead of always favouring I. Writes
//                     stay lowest priority either way.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_miss / i_miss_addr      I-cache miss request (level) and address
//   d_miss / d_miss_addr      D-cache miss request (level) and address
//   d_wr_req / d_wr_addr /
//   d_wr_data                 write-through request (level), address, data
//   mem_addr, mem_enable,
//   mem_wr, mem_data_in       request side of memory4c
//   mem_data_out,
//   mem_data_valid            read-return side of memory4c
//   fill_data, fill_word      returning word and its index within the block
//   i_fill_we, d_fill_we      data-array write strobes for each cache
//   i_fill_done, d_fill_done  one-cycle block-complete pulses
//   d_wr_ack                  one-cycle write-accepted pulse
//   i_stall, d_stall          pipeline stalls for fetch and memory stages
// ---------------------------------------------------------------------------
module mem_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 4,
  parameter int WORDS       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_miss,
  input  logic [ADDR_W-1:0]        i_miss_addr,
  input  logic                     d_miss,
  input  logic [ADDR_W-1:0]        d_miss_addr,
  input  logic                     d_wr_req,
  input  logic [ADDR_W-1:0]        d_wr_addr,
  input  logic [15:0]              d_wr_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [15:0]              mem_data_in,
  input  logic [15:0]              mem_data_out,
  input  logic                     mem_data_valid,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_fill_done,
  output logic                     d_fill_done,
  output logic                     d_wr_ack,
  output logic                     i_stall,
  output logic                     d_stall
);

  localparam int CNT_W   = $clog2(WORDS);
  // Byte offset bits inside one block (16-bit words, so one extra bit).
  localparam int BLK_LSB = CNT_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'((1 << BLK_LSB) - 1);
  localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(WORDS - 1);
  localparam logic [CNT_W:0]    ISSUE_INC = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0]  RX_INC    = CNT_W'(1);

  if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || MEM_LATENCY < 1) begin : g_bad_params
    $error("mem_fill_arbiter: WORDS must be a power of two >= 2, MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IFILL = 2'd1,
    DFILL = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  // One bit wider than a word index: the top bit marks the issue phase done.
  logic [CNT_W:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   issue_offset;
  logic                grant_i, grant_d;

`ifdef MEM_ARB_FAIR_EN
  // 1 = the D-side was the last miss served, 0 = the I-side was.
  logic last_grant_q, last_grant_d;
  assign grant_i = i_miss && (!d_miss || last_grant_q);
`else
  assign grant_i = i_miss;
`endif
  assign grant_d = d_miss && !grant_i;

  // The base has its low block bits cleared, so OR-ing in the word offset
  // can never carry into the block number.
  assign issue_offset = {{(ADDR_W - BLK_LSB){1'b0}}, issue_cnt_q[CNT_W-1:0], 1'b0};

  assign fill_data = mem_data_out;
  assign i_stall   = i_miss || (state_q == IFILL);
  assign d_stall   = d_miss || d_wr_req || (state_q == DFILL) || (state_q == WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      base_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      base_q      <= base_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  // Reset to "D served last" so the first contention goes to the I-side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    base_d      = base_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
`ifdef MEM_ARB_FAIR_EN
    last_grant_d = last_grant_q;
`endif
    mem_addr    = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_data_in = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          state_d     = grant_i ? IFILL : DFILL;
          base_d      = (grant_i ? i_miss_addr : d_miss_addr) & BLK_MASK;
          issue_cnt_d = '0;
          rx_cnt_d    = '0;
`ifdef MEM_ARB_FAIR_EN
          last_grant_d = grant_d;
`endif
        end else if (d_wr_req) begin
          state_d   = WRITE;
          wr_addr_d = d_wr_addr;
          wr_data_d = d_wr_data;
        end
      end

      IFILL, DFILL: begin
        if (!issue_cnt_q[CNT_W]) begin
          mem_enable  = 1'b1;
          mem_addr    = base_q | issue_offset;
          issue_cnt_d = issue_cnt_q + ISSUE_INC;
        end
        // Memory returns words in issue order, so the receive count is
        // the word index; the last one also completes the block.
        if (mem_data_valid) begin
          fill_word = rx_cnt_q;
          i_fill_we = (state_q == IFILL);
          d_fill_we = (state_q == DFILL);
          rx_cnt_d  = rx_cnt_q + RX_INC;
          if (rx_cnt_q == RX_LAST) begin
            i_fill_done = (state_q == IFILL);
            d_fill_done = (state_q == DFILL);
            state_d     = IDLE;
          end
        end
      end

      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = wr_addr_q;
        mem_data_in = wr_data_q;
        d_wr_ack    = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
